// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture/readout sequencer.
package capture_pkg;

    typedef enum logic [2:0] {IDLE, CAP, PRE, RD, GAP, DONE} cap_state_e;

    localparam int unsigned BASE_LEN = 216;

    // Frame length in words: 216 doubled once per code step.
    function automatic int unsigned len_decode(input logic [1:0] code);
        return BASE_LEN << code;
    endfunction

endpackage

// File: rtl/capture_seq_ctrl_if.sv
// Capture memory ports plus the packet stream toward the packetizer.
interface capture_seq_ctrl_if #(parameter int ADDR_W = 11);

    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              pkt_valid_o;
    logic              pkt_sop_o;
    logic              pkt_eop_o;

    modport master (
        output wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
        output pkt_valid_o, pkt_sop_o, pkt_eop_o
    );

    modport slave (
        input wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
        input pkt_valid_o, pkt_sop_o, pkt_eop_o
    );

endinterface

// File: rtl/cap_interval_cnt.sv
// Load/decrement interval counter shared by the PRE and GAP phases.
module cap_interval_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         bypass,
    output logic         last
);

    logic [W-1:0] cnt;

    // A zero-length interval is skipped entirely by the FSM.
    assign bypass = (load_val == '0);
    assign last   = (cnt == W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/capture_seq_ctrl.sv
// Capture/readout sequencer: fills one frame from the ADC, then reads it back
// as a single framed packet bounded by idle and gap intervals.
module capture_seq_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int GAP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             again_i,
    input  logic [1:0]       data_len_i,
    input  logic [1:0]       idle_len_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             adc_valid_i,
    capture_seq_ctrl_if.master bus,
    output logic             busy_o,
    output logic             cap_done_o,
    output logic             rd_done_o
);

    localparam int CNT_W = (GAP_W > 4) ? GAP_W : 4;

    cap_state_e        state;
    logic [1:0]        code_q;
    logic [1:0]        idle_q;
    logic [GAP_W-1:0]  gap_q;
    logic [ADDR_W-1:0] wr_addr, rd_addr, last_addr;
    logic              rd_en, pkt_valid, pkt_sop, pkt_eop;
    logic              wr_fire, wr_last, rd_last;
    logic              cnt_load, cnt_dec, cnt_bypass, cnt_last;
    logic [CNT_W-1:0]  cnt_val;

    assign last_addr = ADDR_W'(len_decode(code_q) - 1);
    assign wr_fire   = adc_valid_i && (state == CAP);
    assign wr_last   = (wr_addr == last_addr);
    assign rd_last   = (rd_addr == last_addr);

    // One counter serves both intervals: loaded with the gap when leaving RD,
    // otherwise with the pre-packet idle.
    assign cnt_val  = (state == RD) ? CNT_W'(gap_q) : CNT_W'({idle_q, 2'b00});
    assign cnt_load = (state == CAP && wr_fire && wr_last) ||
                      (state == DONE && again_i && !start_i) ||
                      (state == RD && rd_last);
    assign cnt_dec  = (state == PRE) || (state == GAP);

    cap_interval_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .bypass   (cnt_bypass),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code_q     <= '0;
            idle_q     <= '0;
            gap_q      <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            pkt_valid  <= 1'b0;
            pkt_sop    <= 1'b0;
            pkt_eop    <= 1'b0;
            busy_o     <= 1'b0;
            cap_done_o <= 1'b0;
            rd_done_o  <= 1'b0;
        end else begin
            cap_done_o <= 1'b0;
            rd_done_o  <= 1'b0;
            pkt_valid  <= rd_en;
            pkt_sop    <= rd_en && (rd_addr == '0);
            pkt_eop    <= rd_en && rd_last;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        code_q  <= data_len_i;
                        idle_q  <= idle_len_i;
                        gap_q   <= gap_i;
                        wr_addr <= '0;
                        busy_o  <= 1'b1;
                        state   <= CAP;
                    end else if (again_i && state == DONE) begin
                        rd_addr <= '0;
                        busy_o  <= 1'b1;
                        if (cnt_bypass) begin
                            rd_en <= 1'b1;
                            state <= RD;
                        end else begin
                            state <= PRE;
                        end
                    end
                end
                CAP: begin
                    if (wr_fire) begin
                        if (wr_last) begin
                            cap_done_o <= 1'b1;
                            rd_addr    <= '0;
                            if (cnt_bypass) begin
                                rd_en <= 1'b1;
                                state <= RD;
                            end else begin
                                state <= PRE;
                            end
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                PRE: begin
                    if (cnt_last) begin
                        rd_en <= 1'b1;
                        state <= RD;
                    end
                end
                RD: begin
                    if (rd_last) begin
                        rd_en <= 1'b0;
                        if (cnt_bypass) begin
                            busy_o    <= 1'b0;
                            rd_done_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_last) begin
                        busy_o    <= 1'b0;
                        rd_done_o <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en_o     = wr_fire;
    assign bus.wr_addr_o   = wr_addr;
    assign bus.rd_en_o     = rd_en;
    assign bus.rd_addr_o   = rd_addr;
    assign bus.pkt_valid_o = pkt_valid;
    assign bus.pkt_sop_o   = pkt_sop;
    assign bus.pkt_eop_o   = pkt_eop;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: expected writes, reads and packet
// beats are queued as stimulus is issued and retired as the DUT produces them.
module tb_capture_seq_ctrl;
    import capture_pkg::*;

    localparam int ADDR_W = 11;
    localparam int GAP_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             again_i = 1'b0;
    logic [1:0]       data_len_i = '0;
    logic [1:0]       idle_len_i = '0;
    logic [GAP_W-1:0] gap_i = '0;
    logic             adc_valid_i = 1'b0;
    logic             busy_o, cap_done_o, rd_done_o;

    capture_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    capture_seq_ctrl #(.ADDR_W(ADDR_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .again_i     (again_i),
        .data_len_i  (data_len_i),
        .idle_len_i  (idle_len_i),
        .gap_i       (gap_i),
        .adc_valid_i (adc_valid_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .cap_done_o  (cap_done_o),
        .rd_done_o   (rd_done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int adc_mode = 0;

    logic [ADDR_W-1:0] exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic [1:0]        exp_pkt[$];

    int wr_cnt, rd_cnt, pkt_cnt;
    int wr_first, wr_last, rd_first, rd_last, eop_cyc, cap_done_cyc, rd_done_cyc;
    int start_cyc, again_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (adc_mode)
                1:       adc_valid_i = 1'b1;
                2:       adc_valid_i = ~adc_valid_i;
                default: adc_valid_i = 1'b0;
            endcase
        end
    end

    // Scoreboard retirement
    initial begin
        logic [ADDR_W-1:0] ea;
        logic [1:0]        ep;
        forever begin
            @(negedge clk);
            if (bus.wr_en_o) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got write addr %0d, none expected", bus.wr_addr_o);
                end else begin
                    ea = exp_wr.pop_front();
                    if (bus.wr_addr_o !== ea) begin
                        errors++;
                        $display("FAIL wr_addr: got %0d expected %0d", bus.wr_addr_o, ea);
                    end
                end
                if (wr_first < 0) wr_first = cyc;
                wr_last = cyc;
                wr_cnt++;
            end
            if (bus.rd_en_o) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got read addr %0d, none expected", bus.rd_addr_o);
                end else begin
                    ea = exp_rd.pop_front();
                    if (bus.rd_addr_o !== ea) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d expected %0d", bus.rd_addr_o, ea);
                    end
                end
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
            end
            if (bus.pkt_valid_o) begin
                checks++;
                if (exp_pkt.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_unexpected: got beat sop/eop %b%b", bus.pkt_sop_o, bus.pkt_eop_o);
                end else begin
                    ep = exp_pkt.pop_front();
                    if ({bus.pkt_sop_o, bus.pkt_eop_o} !== ep) begin
                        errors++;
                        $display("FAIL pkt_flags: got sop/eop %b%b expected %b", bus.pkt_sop_o, bus.pkt_eop_o, ep);
                    end
                end
                pkt_cnt++;
            end else if (bus.pkt_sop_o || bus.pkt_eop_o) begin
                errors++;
                $display("FAIL pkt_flags_idle: sop/eop %b%b without valid", bus.pkt_sop_o, bus.pkt_eop_o);
            end
            if (bus.pkt_eop_o) eop_cyc = cyc;
            if (cap_done_o) cap_done_cyc = cyc;
            if (rd_done_o) rd_done_cyc = cyc;
        end
    end

    task automatic arm();
        wr_cnt = 0; rd_cnt = 0; pkt_cnt = 0;
        wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
        eop_cyc = -1; cap_done_cyc = -1; rd_done_cyc = -1;
    endtask

    task automatic push_writes(input int len);
        for (int i = 0; i < len; i++) exp_wr.push_back(ADDR_W'(i));
    endtask

    task automatic push_reads(input int len);
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(ADDR_W'(i));
            exp_pkt.push_back({(i == 0), (i == len - 1)});
        end
    endtask

    // Issue start with a config, then scramble the config inputs so only
    // the latched copy can be in use afterwards.
    task automatic do_start(input logic [1:0] code, input logic [1:0] idle, input logic [GAP_W-1:0] gap);
        @(posedge clk); #1;
        data_len_i = code; idle_len_i = idle; gap_i = gap;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        start_cyc = cyc;
        data_len_i = ~code; idle_len_i = ~idle; gap_i = ~gap;
    endtask

    task automatic pulse_again();
        @(posedge clk); #1;
        again_i = 1'b1;
        @(posedge clk); #1;
        again_i = 1'b0;
        again_cyc = cyc;
    endtask

    task automatic wait_rd_done(input int budget, output bit ok, output int busy_low);
        ok = 1'b0;
        busy_low = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_done_o) begin
                ok = 1'b1;
                break;
            end
            if (!busy_o) busy_low++;
        end
        #1;
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_pkt.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: left wr=%0d rd=%0d pkt=%0d, required 0", tag,
                     exp_wr.size(), exp_rd.size(), exp_pkt.size());
        end
    endtask

    task automatic test_reset();
        adc_mode = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.wr_en_o, bus.rd_en_o, bus.pkt_valid_o, bus.pkt_sop_o, bus.pkt_eop_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {bus.wr_en_o, bus.rd_en_o, bus.pkt_valid_o, bus.pkt_sop_o, bus.pkt_eop_o});
        end
        checks++;
        if (bus.wr_addr_o !== '0 || bus.rd_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_addr: wr=%0d rd=%0d required 0", bus.wr_addr_o, bus.rd_addr_o);
        end
        checks++;
        if ({busy_o, cap_done_o, rd_done_o} !== 3'b0) begin
            errors++;
            $display("FAIL reset_status: got %b required 000", {busy_o, cap_done_o, rd_done_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_again_idle();
        int busy_seen = 0;
        arm();
        pulse_again();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_o) busy_seen++;
        end
        #1;
        checks++;
        if (wr_cnt != 0 || rd_cnt != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL again_idle: wr=%0d rd=%0d busy=%0d required 0", wr_cnt, rd_cnt, busy_seen);
        end
    endtask

    task automatic test_basic();
        bit ok; int bl;
        arm();
        adc_mode = 1;
        push_writes(216);
        push_reads(216);
        do_start(2'b00, 2'd1, 4'd4);
        wait_rd_done(2000, ok, bl);
        checks++;
        if (!ok || bl != 0) begin
            errors++;
            $display("FAIL basic_done: done=%0d busy_low=%0d required 1/0", ok, bl);
        end
        checks++;
        if (wr_cnt != 216 || wr_first != start_cyc || cap_done_cyc != wr_last + 1) begin
            errors++;
            $display("FAIL basic_capture: wr=%0d first=%0d capdone=%0d required 216/%0d/%0d",
                     wr_cnt, wr_first, cap_done_cyc, start_cyc, wr_last + 1);
        end
        checks++;
        if (rd_first != cap_done_cyc + 4 || rd_last != rd_first + 215) begin
            errors++;
            $display("FAIL basic_read_timing: first=%0d last=%0d required %0d/%0d",
                     rd_first, rd_last, cap_done_cyc + 4, rd_first + 215);
        end
        checks++;
        if (eop_cyc != rd_last + 1 || rd_done_cyc != rd_last + 5) begin
            errors++;
            $display("FAIL basic_tail: eop=%0d rd_done=%0d required %0d/%0d",
                     eop_cyc, rd_done_cyc, rd_last + 1, rd_last + 5);
        end
        check_drained("basic");
    endtask

    task automatic test_replay();
        bit ok; int bl;
        for (int r = 0; r < 2; r++) begin
            arm();
            push_reads(216);
            pulse_again();
            wait_rd_done(1000, ok, bl);
            checks++;
            if (!ok || bl != 0 || wr_cnt != 0 || rd_cnt != 216) begin
                errors++;
                $display("FAIL replay%0d: done=%0d busy_low=%0d wr=%0d rd=%0d required 1/0/0/216",
                         r, ok, bl, wr_cnt, rd_cnt);
            end
            checks++;
            if (rd_first != again_cyc + 4) begin
                errors++;
                $display("FAIL replay%0d_latency: first read %0d required %0d", r, rd_first, again_cyc + 4);
            end
            check_drained("replay");
        end
    endtask

    task automatic test_start_during_rd();
        bit ok, seen; int bl;
        arm();
        push_reads(216);
        pulse_again();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rd_en_o) begin
                seen = 1'b1;
                break;
            end
        end
        do_start(2'b11, 2'd0, 4'd0);
        wait_rd_done(1000, ok, bl);
        checks++;
        if (!seen || !ok || wr_cnt != 0 || rd_cnt != 216) begin
            errors++;
            $display("FAIL start_during_rd: rd_seen=%0d done=%0d wr=%0d rd=%0d required 1/1/0/216",
                     seen, ok, wr_cnt, rd_cnt);
        end
        check_drained("start_during_rd");
    endtask

    task automatic test_start_again_done();
        bit ok; int bl;
        arm();
        push_writes(432);
        push_reads(432);
        @(posedge clk); #1;
        data_len_i = 2'b01; idle_len_i = 2'd0; gap_i = 4'd1;
        start_i = 1'b1; again_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; again_i = 1'b0;
        start_cyc = cyc;
        wait_rd_done(3000, ok, bl);
        checks++;
        if (!ok || wr_cnt != 432 || rd_cnt != 432 || wr_first != start_cyc) begin
            errors++;
            $display("FAIL start_again_done: done=%0d wr=%0d rd=%0d first_wr=%0d required 1/432/432/%0d",
                     ok, wr_cnt, rd_cnt, wr_first, start_cyc);
        end
        check_drained("start_again_done");
    endtask

    task automatic test_long_toggle();
        bit ok; int bl;
        arm();
        adc_mode = 2;
        push_writes(1728);
        push_reads(1728);
        do_start(2'b11, 2'd2, 4'd3);
        wait_rd_done(8000, ok, bl);
        adc_mode = 1;
        checks++;
        if (!ok || bl != 0) begin
            errors++;
            $display("FAIL long_busy: done=%0d busy_low=%0d required 1/0", ok, bl);
        end
        checks++;
        if (wr_cnt != 1728 || rd_cnt != 1728) begin
            errors++;
            $display("FAIL long_counts: wr=%0d rd=%0d required 1728/1728", wr_cnt, rd_cnt);
        end
        checks++;
        if (rd_done_cyc != rd_last + 4) begin
            errors++;
            $display("FAIL long_gap: rd_done=%0d required %0d", rd_done_cyc, rd_last + 4);
        end
        check_drained("long");
    endtask

    task automatic test_gap0_idle0();
        bit ok; int bl;
        arm();
        adc_mode = 1;
        push_writes(216);
        push_reads(216);
        do_start(2'b00, 2'd0, 4'd0);
        wait_rd_done(2000, ok, bl);
        checks++;
        if (!ok || rd_first != cap_done_cyc) begin
            errors++;
            $display("FAIL gap0_direct_rd: done=%0d first_rd=%0d required 1/%0d", ok, rd_first, cap_done_cyc);
        end
        checks++;
        if (eop_cyc != rd_done_cyc || rd_done_cyc != rd_last + 1) begin
            errors++;
            $display("FAIL gap0_tail: eop=%0d rd_done=%0d required %0d/%0d",
                     eop_cyc, rd_done_cyc, rd_last + 1, rd_last + 1);
        end
        check_drained("gap0");
    endtask

    task automatic test_reset_mid_rd();
        bit ok, hit; int bl;
        arm();
        adc_mode = 1;
        push_writes(216);
        push_reads(216);
        do_start(2'b00, 2'd1, 4'd2);
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rd_en_o && bus.rd_addr_o == ADDR_W'(100)) begin
                hit = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_wr.delete(); exp_rd.delete(); exp_pkt.delete();
        @(negedge clk);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_rd_reach: word 100 never read");
        end
        checks++;
        if ({bus.wr_en_o, bus.rd_en_o, bus.pkt_valid_o, bus.pkt_sop_o, bus.pkt_eop_o,
             busy_o, cap_done_o, rd_done_o} !== 8'b0 || bus.wr_addr_o !== '0 || bus.rd_addr_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_rd_outputs: strobes=%b wr=%0d rd=%0d required all 0",
                     {bus.wr_en_o, bus.rd_en_o, bus.pkt_valid_o, bus.pkt_sop_o, bus.pkt_eop_o,
                      busy_o, cap_done_o, rd_done_o}, bus.wr_addr_o, bus.rd_addr_o);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_rd_state: got %0d required IDLE", dut.state);
        end
        rst = 1'b0;
        arm();
        push_writes(216);
        push_reads(216);
        do_start(2'b00, 2'd1, 4'd2);
        wait_rd_done(2000, ok, bl);
        checks++;
        if (!ok || bl != 0 || wr_cnt != 216 || rd_cnt != 216 || rd_done_cyc != rd_last + 3) begin
            errors++;
            $display("FAIL rst_recover: done=%0d busy_low=%0d wr=%0d rd=%0d rd_done=%0d required 1/0/216/216/%0d",
                     ok, bl, wr_cnt, rd_cnt, rd_done_cyc, rd_last + 3);
        end
        check_drained("rst_recover");
    endtask

    initial begin
        arm();
        test_reset();
        test_again_idle();
        test_basic();
        test_replay();
        test_start_during_rd();
        test_start_again_done();
        test_long_toggle();
        test_gap0_idle0();
        test_reset_mid_rd();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
